mp1_control: RTL and testbench
==============================

# mp1_control

Multicycle control state machine for the RV32I datapath. It sequences fetch, decode, execute and memory access by driving every load enable, mux select, ALU/compare opcode and the memory read/write handshake, using the opcode, funct3, funct7 and br_en fed back from the datapath. It sits beside the datapath in the top-level CPU and is the only agent that talks to the memory handshake.

## Interface
Parameters: none.

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  7  IR opcode field
- funct3  in  3  IR funct3
- funct7  in  7  IR funct7
- br_en  in  1  comparator result
- mem_resp  in  1  memory done, sampled at rising edge
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  register enables
- pcmux_sel  out  1  0 = pc+4, 1 = alu_out
- alumux1_sel  out  1  0 = rs1, 1 = pc
- alumux2_sel  out  2  0 = i_imm, 1 = u_imm, 2 = b_imm, 3 = s_imm
- regfilemux_sel  out  2  0 = alu_out, 1 = br_en, 2 = u_imm, 3 = MDR
- marmux_sel  out  1  0 = pc, 1 = alu_out
- cmpmux_sel  out  1  0 = rs2, 1 = i_imm
- aluop  out  3  0 add, 1 sll, 2 sra, 3 sub, 4 xor, 5 srl, 6 or, 7 and
- cmpop  out  3  branch funct3 encoding (beq 0, bne 1, blt 4, bge 5, bltu 6, bgeu 7)
- mem_read, mem_write  out  1 each  memory strobes
- mem_byte_enable  out  4  always 4'b1111
- illegal  out  1  illegal-opcode flag (see Configuration)

## Operation
- Default every cycle: all loads/strobes 0, all selects 0, aluop add, cmpop beq, illegal 0.
- FETCH1: load_mar, marmux=pc. -> FETCH2.
- FETCH2: mem_read, load_mdr; stays until mem_resp=1, then -> FETCH3.
- FETCH3: load_ir. -> DECODE.
- DECODE: no outputs; branches on opcode: 0110111 LUI, 0010111 AUIPC, 1100011 BR, 0000011/0100011 CALC_ADDR, 0010011 IMM, 0110011 REG, else ILLEGAL handling.
- LUI: load_regfile, regfilemux=u_imm, load_pc. -> FETCH1.
- AUIPC: alumux1=pc, alumux2=u_imm, add, load_regfile, load_pc. -> FETCH1.
- BR: cmpop=funct3, cmpmux=rs2, alumux1=pc, alumux2=b_imm, add, load_pc, pcmux=br_en. -> FETCH1.
- IMM: load_regfile, load_pc; funct3 010/011: cmpmux=i_imm, cmpop blt/bltu, regfilemux=br_en; funct3 101: aluop sra if funct7[5] else srl; other funct3: aluop=funct3 mapping (000 add, 001 sll, 100 xor, 110 or, 111 and). alumux2=i_imm.
- REG: as IMM but cmpmux=rs2 for slt/sltu, ALU operand b from rs2 is not available; REG supports only slt/sltu in this revision and treats other funct3 as IMM-style ALU op on i_imm is forbidden -> REG ALU forms follow Configuration (illegal).
- CALC_ADDR: alumux2 = i_imm (load) or s_imm (store), add, load_mar, marmux=alu_out; store also load_data_out. -> LD1 or ST1.
- LD1: mem_read, load_mdr; hold until mem_resp. -> LD2.
- LD2: load_regfile, regfilemux=MDR, load_pc. -> FETCH1.
- ST1: mem_write; hold until mem_resp. -> ST2.
- ST2: load_pc. -> FETCH1.

## Timing
- Outputs are combinational from state and IR fields; state updates on rising clk.
- While rst=0 all outputs 0, state forced to FETCH1 immediately (asynchronous); first fetch starts on first edge after rst rises.
- Latency with single-cycle mem_resp: ALU/LUI/AUIPC/BR 5 cycles, store 7, load 7.
- mem_read/mem_write held constant and address stable until the edge sampling mem_resp=1; strobe deasserts the following cycle.
- mem_resp outside FETCH2/LD1/ST1 ignored. Reset mid-wait abandons the access.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: unsupported opcode or REG funct3 outside 010/011 -> HALT state, illegal=1, all other outputs 0, remains until reset.
- Undefined: such instructions execute as NOP (load_pc, pcmux=pc+4, -> FETCH1); illegal tied 0.

## Test plan
- Reset low 3 cycles, release -> all outputs 0 during reset; cycle 1 load_mar=1, marmux=0.
- Fetch with mem_resp delayed 4 cycles -> mem_read held 4 cycles at FETCH2, then load_ir one cycle.
- addi x1,x0,5 (0x00500093) -> EXEC cycle: load_regfile=1, aluop=0, alumux2=0, regfilemux=0, load_pc=1.
- beq with br_en=1 -> pcmux_sel=1, alumux1=1, alumux2=2; br_en=0 -> pcmux_sel=0.
- lw then sw, 1-cycle mem -> 7 cycles each; store asserts load_data_out in CALC_ADDR and mem_write in ST1 with mem_byte_enable=4'b1111.
- opcode 0x7F with macro -> illegal=1 sticky; without macro -> NOP, pc advances.

Source files
------------

// File: rtl/mp1_control_if.sv
// Control/datapath/memory bundle for the RV32I multicycle controller.
// master = controller side, slave = datapath and memory side.
interface mp1_control_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       br_en;
  logic       mem_resp;

  logic       load_pc;
  logic       load_ir;
  logic       load_regfile;
  logic       load_mar;
  logic       load_mdr;
  logic       load_data_out;
  logic       pcmux_sel;
  logic       alumux1_sel;
  logic [1:0] alumux2_sel;
  logic [1:0] regfilemux_sel;
  logic       marmux_sel;
  logic       cmpmux_sel;
  logic [2:0] aluop;
  logic [2:0] cmpop;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] mem_byte_enable;
  logic       illegal;

  modport master (
    input  opcode, funct3, funct7, br_en, mem_resp,
    output load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
           pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
           cmpmux_sel, aluop, cmpop, mem_read, mem_write, mem_byte_enable, illegal
  );

  modport slave (
    output opcode, funct3, funct7, br_en, mem_resp,
    input  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
           pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel,
           cmpmux_sel, aluop, cmpop, mem_read, mem_write, mem_byte_enable, illegal
  );
endinterface

// File: rtl/mp1_control.sv
// Multicycle RV32I control FSM; Moore-style outputs, all forced low while rst is low.
// Define CTRL_ILLEGAL_TRAP_EN to halt on unsupported instructions (default: execute as NOP).
module mp1_control (
  input  logic          clk,
  input  logic          rst,
  mp1_control_if.master bus
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE, LUI, AUIPC, BR, CALC_ADDR,
    IMM, REG, LD1, LD2, ST1, ST2, ILL
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_unused;

  assign w_unused = ^{bus.funct7[6], bus.funct7[4:0]};
  assign bus.mem_byte_enable = 4'b1111;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FETCH1;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    bus.load_pc        = 1'b0;
    bus.load_ir        = 1'b0;
    bus.load_regfile   = 1'b0;
    bus.load_mar       = 1'b0;
    bus.load_mdr       = 1'b0;
    bus.load_data_out  = 1'b0;
    bus.pcmux_sel      = 1'b0;
    bus.alumux1_sel    = 1'b0;
    bus.alumux2_sel    = 2'd0;
    bus.regfilemux_sel = 2'd0;
    bus.marmux_sel     = 1'b0;
    bus.cmpmux_sel     = 1'b0;
    bus.aluop          = 3'd0;
    bus.cmpop          = 3'd0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.illegal        = 1'b0;

    if (rst) begin
      case (r_state)
        FETCH1: begin
          bus.load_mar = 1'b1;
          w_next       = FETCH2;
        end
        FETCH2: begin
          bus.mem_read = 1'b1;
          bus.load_mdr = 1'b1;
          if (bus.mem_resp) w_next = FETCH3;
        end
        FETCH3: begin
          bus.load_ir = 1'b1;
          w_next      = DECODE;
        end
        DECODE: begin
          case (bus.opcode)
            OP_LUI:             w_next = LUI;
            OP_AUIPC:           w_next = AUIPC;
            OP_BR:              w_next = BR;
            OP_LOAD, OP_STORE:  w_next = CALC_ADDR;
            OP_IMM:             w_next = IMM;
            // REG only implements slt/sltu; the rest take the illegal path
            OP_REG:             w_next = (bus.funct3[2:1] == 2'b01) ? REG : ILL;
            default:            w_next = ILL;
          endcase
        end
        LUI: begin
          bus.load_regfile   = 1'b1;
          bus.regfilemux_sel = 2'd2;
          bus.load_pc        = 1'b1;
          w_next             = FETCH1;
        end
        AUIPC: begin
          bus.alumux1_sel  = 1'b1;
          bus.alumux2_sel  = 2'd1;
          bus.load_regfile = 1'b1;
          bus.load_pc      = 1'b1;
          w_next           = FETCH1;
        end
        BR: begin
          bus.cmpop       = bus.funct3;
          bus.alumux1_sel = 1'b1;
          bus.alumux2_sel = 2'd2;
          bus.load_pc     = 1'b1;
          bus.pcmux_sel   = bus.br_en;
          w_next          = FETCH1;
        end
        IMM: begin
          bus.load_regfile = 1'b1;
          bus.load_pc      = 1'b1;
          if (bus.funct3[2:1] == 2'b01) begin
            bus.cmpmux_sel     = 1'b1;
            bus.cmpop          = bus.funct3[0] ? 3'd6 : 3'd4;
            bus.regfilemux_sel = 2'd1;
          end else if (bus.funct3 == 3'b101) begin
            bus.aluop = bus.funct7[5] ? 3'd2 : 3'd5;
          end else begin
            bus.aluop = bus.funct3;
          end
          w_next = FETCH1;
        end
        REG: begin
          bus.load_regfile   = 1'b1;
          bus.load_pc        = 1'b1;
          bus.cmpop          = bus.funct3[0] ? 3'd6 : 3'd4;
          bus.regfilemux_sel = 2'd1;
          w_next             = FETCH1;
        end
        CALC_ADDR: begin
          bus.load_mar   = 1'b1;
          bus.marmux_sel = 1'b1;
          if (bus.opcode == OP_STORE) begin
            bus.alumux2_sel   = 2'd3;
            bus.load_data_out = 1'b1;
            w_next            = ST1;
          end else begin
            w_next = LD1;
          end
        end
        LD1: begin
          bus.mem_read = 1'b1;
          bus.load_mdr = 1'b1;
          if (bus.mem_resp) w_next = LD2;
        end
        LD2: begin
          bus.load_regfile   = 1'b1;
          bus.regfilemux_sel = 2'd3;
          bus.load_pc        = 1'b1;
          w_next             = FETCH1;
        end
        ST1: begin
          bus.mem_write = 1'b1;
          if (bus.mem_resp) w_next = ST2;
        end
        ST2: begin
          bus.load_pc = 1'b1;
          w_next      = FETCH1;
        end
        ILL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          bus.illegal = 1'b1;
          w_next      = ILL;
`else
          bus.load_pc = 1'b1;
          w_next      = FETCH1;
`endif
        end
        default: w_next = FETCH1;
      endcase
    end
  end

endmodule

// File: tb/tb_mp1_control.sv
// Randomized bench for mp1_control: a per-instruction expected-cycle model drives
// memory latency and instruction fields, and every cycle's outputs are compared.
module tb_mp1_control;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_data_out;
    logic       pcmux;
    logic       alumux1;
    logic [1:0] alumux2;
    logic [1:0] regfilemux;
    logic       marmux;
    logic       cmpmux;
    logic [2:0] aluop;
    logic [2:0] cmpop;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t c;
    logic mem;
    logic halt;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  step_t exp_q[$];
  ctl_t  obs;
  logic [2:0] imm_alu [8] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd4, 3'd0, 3'd6, 3'd7};

  always #5 clk = ~clk;

  mp1_control_if bus ();
  mp1_control dut (.clk(clk), .rst(rst), .bus(bus));

  assign obs = {bus.load_pc, bus.load_ir, bus.load_regfile, bus.load_mar, bus.load_mdr,
                bus.load_data_out, bus.pcmux_sel, bus.alumux1_sel, bus.alumux2_sel,
                bus.regfilemux_sel, bus.marmux_sel, bus.cmpmux_sel, bus.aluop, bus.cmpop,
                bus.mem_read, bus.mem_write, bus.illegal};

  // Called at a falling edge with inputs already applied; advances one cycle.
  task automatic chk(input string tag, input ctl_t e);
    #1;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s ctl observed=%h expected=%h", tag, obs, e);
    end
    checks++;
    assert (bus.mem_byte_enable === 4'b1111) else begin
      errors++;
      $error("FAIL %s byte_enable observed=%h expected=f", tag, bus.mem_byte_enable);
    end
    @(negedge clk);
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'h37, 7'h17, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  function automatic void push(input ctl_t c, input logic m, input logic h);
    step_t s;
    s.c = c; s.mem = m; s.halt = h;
    exp_q.push_back(s);
  endfunction

  // Expected cycles after DECODE for one instruction, from the ISA-level rules.
  function automatic void build(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic br);
    ctl_t c;
    c = '0;
    exp_q.delete();
    if (op == 7'h37) begin
      c.load_regfile = 1; c.regfilemux = 2; c.load_pc = 1; push(c, 0, 0);
    end else if (op == 7'h17) begin
      c.alumux1 = 1; c.alumux2 = 1; c.load_regfile = 1; c.load_pc = 1; push(c, 0, 0);
    end else if (op == 7'h63) begin
      c.cmpop = f3; c.alumux1 = 1; c.alumux2 = 2; c.load_pc = 1; c.pcmux = br;
      push(c, 0, 0);
    end else if (op == 7'h13) begin
      c.load_regfile = 1; c.load_pc = 1;
      if (f3 == 3'd2 || f3 == 3'd3) begin
        c.cmpmux = 1; c.regfilemux = 1; c.cmpop = (f3 == 3'd2) ? 3'd4 : 3'd6;
      end else if (f3 == 3'd5) begin
        c.aluop = f7[5] ? 3'd2 : 3'd5;
      end else begin
        c.aluop = imm_alu[f3];
      end
      push(c, 0, 0);
    end else if (op == 7'h33 && (f3 == 3'd2 || f3 == 3'd3)) begin
      c.load_regfile = 1; c.load_pc = 1; c.regfilemux = 1;
      c.cmpop = (f3 == 3'd2) ? 3'd4 : 3'd6;
      push(c, 0, 0);
    end else if (op == 7'h03) begin
      c.load_mar = 1; c.marmux = 1; push(c, 0, 0);
      c = '0; c.mem_read = 1; c.load_mdr = 1; push(c, 1, 0);
      c = '0; c.load_regfile = 1; c.regfilemux = 3; c.load_pc = 1; push(c, 0, 0);
    end else if (op == 7'h23) begin
      c.load_mar = 1; c.marmux = 1; c.alumux2 = 3; c.load_data_out = 1; push(c, 0, 0);
      c = '0; c.mem_write = 1; push(c, 1, 0);
      c = '0; c.load_pc = 1; push(c, 0, 0);
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      c.illegal = 1; push(c, 0, 1);
`else
      c.load_pc = 1; push(c, 0, 0);
`endif
    end
  endfunction

  task automatic mem_wait(input string tag, input ctl_t c, input int dly);
    for (int i = 0; i <= dly; i++) begin
      bus.mem_resp = (i == dly);
      chk(tag, c);
    end
    bus.mem_resp = 1'b0;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic br, input int fdly, input int mdly);
    ctl_t c;
    bus.br_en = br;
    c = '0; c.load_mar = 1;
    bus.mem_resp = 1'($urandom_range(0, 1));
    chk("fetch1", c);
    c = '0; c.mem_read = 1; c.load_mdr = 1;
    mem_wait("fetch2", c, fdly);
    bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    c = '0; c.load_ir = 1;
    bus.mem_resp = 1'($urandom_range(0, 1));
    chk("fetch3", c);
    bus.mem_resp = 1'($urandom_range(0, 1));
    chk("decode", '0);
    build(op, f3, f7, br);
    foreach (exp_q[k]) begin
      if (exp_q[k].mem) begin
        mem_wait("memop", exp_q[k].c, mdly);
      end else begin
        bus.mem_resp = 1'($urandom_range(0, 1));
        chk("exec", exp_q[k].c);
      end
      if (exp_q[k].halt) begin
        for (int h = 0; h < 4; h++) begin
          bus.mem_resp = 1'($urandom_range(0, 1));
          chk("halt_sticky", exp_q[k].c);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mem_resp = 1'($urandom_range(0, 1));
      chk("reset", '0);
    end
    rst = 1'b1;
  endtask

  initial begin
    logic [6:0] op;
    logic [6:0] f7;
    ctl_t c;
    bus.opcode = 7'h00; bus.funct3 = 3'd0; bus.funct7 = 7'h00;
    bus.br_en = 1'b0;   bus.mem_resp = 1'b0;
    @(negedge clk);
    do_reset();

    run_instr(7'h13, 3'd0, 7'h00, 1'b0, 3, 0);   // addi x1,x0,5
    run_instr(7'h63, 3'd0, 7'h00, 1'b1, 0, 0);   // beq taken
    run_instr(7'h63, 3'd0, 7'h00, 1'b0, 0, 0);   // beq not taken
    run_instr(7'h03, 3'd2, 7'h00, 1'b0, 0, 0);   // lw
    run_instr(7'h23, 3'd2, 7'h00, 1'b0, 0, 0);   // sw
    run_instr(7'h13, 3'd5, 7'h20, 1'b0, 0, 0);   // srai
    run_instr(7'h33, 3'd3, 7'h00, 1'b1, 1, 0);   // sltu
    run_instr(7'h03, 3'd2, 7'h00, 1'b0, 2, 3);   // lw with slow memory
    run_instr(7'h23, 3'd2, 7'h00, 1'b0, 1, 2);   // sw with slow memory

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0: op = 7'h37;
        1: op = 7'h17;
        2: op = 7'h63;
        3: op = 7'h03;
        4: op = 7'h23;
        5: op = 7'h13;
        6: op = 7'h33;
        default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          op = 7'h13;
`else
          op = 7'($urandom_range(0, 127));
          while (is_legal(op)) op = 7'($urandom_range(0, 127));
`endif
        end
      endcase
      f7 = 7'($urandom_range(0, 127));
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (op == 7'h33) begin
        run_instr(op, 3'($urandom_range(2, 3)), f7, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
        continue;
      end
`endif
      run_instr(op, 3'($urandom_range(0, 7)), f7, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset in the middle of a fetch wait abandons the access
    c = '0; c.load_mar = 1;
    chk("pre_abort_fetch1", c);
    c = '0; c.mem_read = 1; c.load_mdr = 1;
    bus.mem_resp = 1'b0;
    chk("pre_abort_fetch2", c);
    chk("pre_abort_fetch2", c);
    do_reset();
    run_instr(7'h37, 3'd0, 7'h00, 1'b0, 0, 0);

    // Unsupported forms: REG add, then opcode 0x7F
    run_instr(7'h33, 3'd0, 7'h00, 1'b0, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    do_reset();
`endif
    run_instr(7'h7F, 3'd0, 7'h00, 1'b0, 0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    do_reset();
`endif
    run_instr(7'h17, 3'd0, 7'h00, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
